// File: rtl/arbiter_pkg.sv
// Shared definitions for the round-robin arbiter family: FSM states, client
// limit and the one-hot to binary encoder used for the grant ID.
package arbiter_pkg;

  localparam int ARB_MAX_CLIENTS = 32;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // OR-combining the indices of set bits is exact for a one-hot input.
  function automatic int unsigned onehot_to_bin(input logic [ARB_MAX_CLIENTS-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < ARB_MAX_CLIENTS; i++) begin
      if (onehot[i]) begin
        idx = idx | unsigned'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbiter_rr_mask_pe.sv
// Combinational round-robin picker: lowest request at or above i_ptr,
// wrapping to the lowest request overall when none sit above the pointer.
module arbiter_rr_mask_pe
  import arbiter_pkg::*;
#(
  parameter  int CLIENTS = 4,
  localparam int N       = $clog2(CLIENTS)
) (
  input  logic [CLIENTS-1:0] i_req,
  input  logic [N-1:0]       i_ptr,
  output logic [CLIENTS-1:0] o_win,
  output logic [N-1:0]       o_win_id,
  output logic               o_any_req
);

  logic [CLIENTS-1:0] w_masked;
  logic [CLIENTS-1:0] w_search;
  logic [CLIENTS-1:0] w_win;

  always_comb begin
    w_masked = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      w_masked[i] = i_req[i] && (i >= int'(i_ptr));
    end
    w_search = (|w_masked) ? w_masked : i_req;
    // Scanning downward leaves the lowest set bit as the final winner.
    w_win = '0;
    for (int i = CLIENTS - 1; i >= 0; i--) begin
      if (w_search[i]) begin
        w_win    = '0;
        w_win[i] = 1'b1;
      end
    end
  end

  assign o_win     = w_win;
  assign o_win_id  = N'(onehot_to_bin(ARB_MAX_CLIENTS'(w_win)));
  assign o_any_req = |i_req;

endmodule

// File: rtl/arbiter_round_robin_ack.sv
// Round-robin arbiter with a registered one-hot grant that is held until the
// winner acknowledges it, or pulsed for one cycle when acks are not used.
module arbiter_round_robin_ack
  import arbiter_pkg::*;
#(
  parameter  int CLIENTS      = 4,
  parameter  bit WAIT_GNT_ACK = 1'b1,
  localparam int N            = $clog2(CLIENTS)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_block_arb,
  input  logic [CLIENTS-1:0] i_req,
  input  logic [CLIENTS-1:0] i_gnt_ack,
  output logic               o_gnt_valid,
  output logic [CLIENTS-1:0] o_gnt,
  output logic [N-1:0]       o_gnt_id
);

  arb_state_t         r_state;
  logic [N-1:0]       r_ptr;
  logic [CLIENTS-1:0] r_gnt;
  logic [N-1:0]       r_gnt_id;
  logic               r_gnt_valid;

  logic [CLIENTS-1:0] w_win;
  logic [N-1:0]       w_win_id;
  logic               w_any_req;
  logic               w_ack;
  logic               w_release;
  logic               w_issue;
  logic [N-1:0]       w_next_ptr;

  arbiter_rr_mask_pe #(
    .CLIENTS (CLIENTS)
  ) u_pick (
    .i_req     (i_req),
    .i_ptr     (r_ptr),
    .o_win     (w_win),
    .o_win_id  (w_win_id),
    .o_any_req (w_any_req)
  );

  // A slot opens when idle, when the current winner acks, or every cycle
  // in pulse mode; only then are block_arb and the requests looked at.
  always_comb begin
    w_ack      = (r_state == ARB_GRANT) && i_gnt_ack[r_gnt_id];
    w_release  = !WAIT_GNT_ACK || (r_state == ARB_IDLE) || w_ack;
    w_issue    = w_release && !i_block_arb && w_any_req;
    w_next_ptr = (w_win_id == N'(CLIENTS - 1)) ? '0 : w_win_id + N'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ARB_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
    end else if (w_issue) begin
      r_state     <= ARB_GRANT;
      r_ptr       <= w_next_ptr;
      r_gnt       <= w_win;
      r_gnt_id    <= w_win_id;
      r_gnt_valid <= 1'b1;
    end else if (w_release) begin
      r_state     <= ARB_IDLE;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
    end
  end

  assign o_gnt_valid = r_gnt_valid;
  assign o_gnt       = r_gnt;
  assign o_gnt_id    = r_gnt_id;

endmodule
